// File: rtl/cpu6_timer.sv
// -----------------------------------------------------------------------------
// cpu6_timer
//
// Memory-mapped machine timer. It answers the cpu6_core M-stage data port,
// holds a 64-bit free-running mtime counter and a 64-bit mtimecmp register,
// and drives the registered timer interrupt request tmr_irq_r.
//
// Bus protocol (single-cycle, no wait states, no valid/ready):
//   - hit is a pure decode of dataaddr against the 32-byte window.
//   - A write commits on the rising edge where memwrite & hit is high.
//   - readdata follows dataaddr combinationally and is 0 when hit is 0,
//     so the SoC read mux can OR or select it freely. A read in the cycle
//     after a write returns the newly written value.
//
// Ports
//   clk         in   1   single clock, all state on the rising edge
//   reset       in   1   asynchronous, active-low reset
//   memwrite    in   1   core store strobe
//   dataaddr    in   32  core data address; bits [1:0] ignored
//   writedata   in   32  core store data
//   readdata    out  32  register read data (combinational)
//   hit         out  1   dataaddr is inside the timer window
//   csr_mtie_r  in   1   mie.MTIE from the core CSR file
//   tmr_irq_r   out  1   registered timer interrupt request
//
// Register map (offset from BASE_ADDR)
//   0x00 MTIME_LO  RW     0x04 MTIME_HI  RW
//   0x08 CMP_LO    RW     0x0C CMP_HI    RW
//   0x10 CTRL      RW  [0]=EN, [8+DIV_W-1:8]=DIV
//   0x14 STATUS    RO  [0]=mtip, [1]=tmr_irq_r
//   0x18, 0x1C     reserved, read 0
//
// mtimecmp is not interlocked: writing it one half at a time can produce a
// transient match, so software writes CMP_HI to all-ones first.
// -----------------------------------------------------------------------------
module cpu6_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          DIV_W     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataaddr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        hit,
    input  logic        csr_mtie_r,
    output logic        tmr_irq_r
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [63:0]      mtime;
    logic [63:0]      mtimecmp;
    logic             ctrl_en;
    logic [DIV_W-1:0] ctrl_div;
    logic [DIV_W-1:0] presc_cnt;

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    logic sel_mtime_lo;
    logic sel_mtime_hi;
    logic sel_cmp_lo;
    logic sel_cmp_hi;
    logic sel_ctrl;
    logic sel_status;

    assign hit = (dataaddr[31:5] == BASE_ADDR[31:5]);

    // Word offset lives in [4:2]; the byte lane bits are don't-care.
    always_comb begin
        sel_mtime_lo = 1'b0;
        sel_mtime_hi = 1'b0;
        sel_cmp_lo   = 1'b0;
        sel_cmp_hi   = 1'b0;
        sel_ctrl     = 1'b0;
        sel_status   = 1'b0;
        if (hit) begin
            casez (dataaddr[4:0])
                5'b000??: sel_mtime_lo = 1'b1;
                5'b001??: sel_mtime_hi = 1'b1;
                5'b010??: sel_cmp_lo   = 1'b1;
                5'b011??: sel_cmp_hi   = 1'b1;
                5'b100??: sel_ctrl     = 1'b1;
                5'b101??: sel_status   = 1'b1;
                default:  ;
            endcase
        end
    end

    logic wr_mtime_lo;
    logic wr_mtime_hi;
    logic wr_cmp_lo;
    logic wr_cmp_hi;
    logic wr_ctrl;

    assign wr_mtime_lo = memwrite & sel_mtime_lo;
    assign wr_mtime_hi = memwrite & sel_mtime_hi;
    assign wr_cmp_lo   = memwrite & sel_cmp_lo;
    assign wr_cmp_hi   = memwrite & sel_cmp_hi;
    assign wr_ctrl     = memwrite & sel_ctrl;

    // -------------------------------------------------------------------------
    // Prescaler
    // -------------------------------------------------------------------------
    // tick fires when the count reaches DIV, so the period is DIV+1 cycles
    // and DIV=0 ticks every cycle. Because a CTRL write clears the count,
    // presc_cnt can never sit above a newly written (smaller) DIV.
    logic tick;

    assign tick = ctrl_en && (presc_cnt == ctrl_div);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_en  <= 1'b1;
            ctrl_div <= '0;
        end else if (wr_ctrl) begin
            ctrl_en  <= writedata[0];
            ctrl_div <= writedata[8 +: DIV_W];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_cnt <= '0;
        end else if (wr_ctrl) begin
            presc_cnt <= '0;
        end else if (ctrl_en) begin
            if (presc_cnt == ctrl_div) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // mtime
    // -------------------------------------------------------------------------
    // A software write to either half wins over the tick: the written half
    // takes writedata, the other half holds, and that cycle's increment is
    // lost. Otherwise the full 64-bit value increments and wraps silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtime <= '0;
        end else if (wr_mtime_lo) begin
            mtime[31:0] <= writedata;
        end else if (wr_mtime_hi) begin
            mtime[63:32] <= writedata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // -------------------------------------------------------------------------
    // mtimecmp
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtimecmp <= '1;
        end else if (wr_cmp_lo) begin
            mtimecmp[31:0] <= writedata;
        end else if (wr_cmp_hi) begin
            mtimecmp[63:32] <= writedata;
        end
    end

    // -------------------------------------------------------------------------
    // Compare and interrupt
    // -------------------------------------------------------------------------
    logic mtip;

    assign mtip = (mtime >= mtimecmp);

    // Level interrupt, one cycle behind the compare / MTIE; it drops only when
    // software moves mtimecmp or mtime, or clears MTIE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr_irq_r <= 1'b0;
        end else begin
            tmr_irq_r <= mtip & csr_mtie_r;
        end
    end

    // -------------------------------------------------------------------------
    // Read mux
    // -------------------------------------------------------------------------
    logic [31:0] ctrl_rdata;
    logic [31:0] status_rdata;

    always_comb begin
        ctrl_rdata              = '0;
        ctrl_rdata[0]           = ctrl_en;
        ctrl_rdata[8 +: DIV_W]  = ctrl_div;
    end

    assign status_rdata = {30'b0, tmr_irq_r, mtip};

    always_comb begin
        readdata = '0;
        if (sel_mtime_lo) readdata = mtime[31:0];
        if (sel_mtime_hi) readdata = mtime[63:32];
        if (sel_cmp_lo)   readdata = mtimecmp[31:0];
        if (sel_cmp_hi)   readdata = mtimecmp[63:32];
        if (sel_ctrl)     readdata = ctrl_rdata;
        if (sel_status)   readdata = status_rdata;
    end

endmodule
